// File: rtl/vid_text_fetch.sv
// Character-row fetch sequencer: reads char/attribute pairs from the screen
// RAM video port for one row and delivers paired cells through a small FIFO.
module vid_text_fetch (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_stb,
  input  logic [4:0] req_y,
  input  logic       abort,
  output logic       busy,
  output logic [5:0] vp_x,
  output logic [4:0] vp_y,
  output logic       vp_sel,
  input  logic [7:0] vp_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_char,
  output logic [3:0] out_attr,
  output logic [5:0] out_x,
  output logic       out_last
);

  localparam int unsigned COLS  = 48;
  localparam int unsigned ROWS  = 28;
  localparam int unsigned LAT   = 3;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 3;
  localparam logic [5:0]  LAST_X = 6'(COLS - 1);
  localparam logic [4:0]  LAST_Y = 5'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE_C, ISSUE_A, DRAIN} state_t;

  typedef struct packed {
    logic [7:0] ch;
    logic [3:0] attr;
    logic [5:0] x;
    logic       last;
  } cell_t;

  state_t           state;
  logic             rst_seen;
  logic             issue_vld;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] cnt;
  cell_t            mem [DEPTH];
  logic [LAT-1:0]   pipe_vld;
  logic [LAT-1:0]   pipe_sel;
  logic [5:0]       pipe_x [LAT];
  logic [7:0]       hold_char;

  logic             pop;
  logic             ret_c;
  logic             ret_a;
  logic             credit;
  logic             accept;
  logic             issue_c;
  logic [CNT_W-1:0] inflight_nx;
  logic [CNT_W-1:0] cnt_nx;
  logic [1:0]       push_idx;

  // Handshake, return decode, credit and next-count helpers.
  assign pop         = out_valid & out_ready;
  assign ret_c       = pipe_vld[LAT-1] & ~pipe_sel[LAT-1];
  assign ret_a       = pipe_vld[LAT-1] &  pipe_sel[LAT-1];
  assign credit      = ({1'b0, cnt} + {1'b0, inflight}) < 4'(DEPTH);
  assign accept      = (state == IDLE) & req_stb & (req_y <= LAST_Y) & rst_seen & ~abort;
  assign issue_c     = accept | ((state == ISSUE_C) & credit & ~abort);
  assign inflight_nx = inflight + CNT_W'(issue_c) - CNT_W'(ret_a);
  assign cnt_nx      = cnt + CNT_W'(ret_a) - CNT_W'(pop);
  assign push_idx    = pop ? 2'(cnt - 3'd1) : 2'(cnt);

  // The first char read is launched on acceptance so it appears the cycle after
  // the request; vp_* therefore always shows the read issued this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      vp_x      <= '0;
      vp_y      <= '0;
      vp_sel    <= 1'b0;
      issue_vld <= 1'b0;
      inflight  <= '0;
      rst_seen  <= 1'b0;
    end else begin
      rst_seen  <= 1'b1;
      issue_vld <= 1'b0;
      if (abort) begin
        state    <= IDLE;
        busy     <= 1'b0;
        inflight <= '0;
      end else begin
        inflight <= inflight_nx;
        case (state)
          IDLE: begin
            if (accept) begin
              vp_x      <= '0;
              vp_y      <= req_y;
              vp_sel    <= 1'b0;
              issue_vld <= 1'b1;
              busy      <= 1'b1;
              state     <= ISSUE_A;
            end
          end
          ISSUE_C: begin
            if (credit) begin
              vp_x      <= vp_x + 6'd1;
              vp_sel    <= 1'b0;
              issue_vld <= 1'b1;
              state     <= ISSUE_A;
            end
          end
          ISSUE_A: begin
            vp_sel    <= 1'b1;
            issue_vld <= 1'b1;
            state     <= (vp_x == LAST_X) ? DRAIN : ISSUE_C;
          end
          DRAIN: begin
            if ((inflight_nx == '0) && (cnt_nx == '0)) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Return pipeline tags each issued read so only real reads are captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld  <= '0;
      pipe_sel  <= '0;
      hold_char <= '0;
      for (int i = 0; i < int'(LAT); i++) pipe_x[i] <= '0;
    end else begin
      if (abort) begin
        pipe_vld <= '0;
      end else begin
        pipe_vld <= {pipe_vld[LAT-2:0], issue_vld};
      end
      pipe_sel  <= {pipe_sel[LAT-2:0], vp_sel};
      pipe_x[0] <= vp_x;
      for (int i = 1; i < int'(LAT); i++) pipe_x[i] <= pipe_x[i-1];
      if (ret_c) hold_char <= vp_data;
    end
  end

  // Shift FIFO: entry 0 is always the head, so outputs come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (abort) begin
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      cnt       <= cnt_nx;
      out_valid <= (cnt_nx != '0);
      if (pop) begin
        for (int i = 0; i < int'(DEPTH) - 1; i++) mem[i] <= mem[i+1];
      end
      if (ret_a) begin
        mem[push_idx] <= '{ch: hold_char, attr: vp_data[3:0], x: pipe_x[LAT-1],
                           last: (pipe_x[LAT-1] == LAST_X)};
      end
    end
  end

  assign out_char = mem[0].ch;
  assign out_attr = mem[0].attr;
  assign out_x    = mem[0].x;
  assign out_last = mem[0].last;

endmodule

// File: tb/tb_vid_text_fetch.sv
// Self-checking bench for vid_text_fetch: screen RAM model, scoreboard queue
// of expected cells, and a monitor comparing every delivered cell.
module tb_vid_text_fetch;

  logic       clk;
  logic       rst_n;
  logic       req_stb;
  logic [4:0] req_y;
  logic       abort;
  logic       busy;
  logic [5:0] vp_x;
  logic [4:0] vp_y;
  logic       vp_sel;
  logic [7:0] vp_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_char;
  logic [3:0] out_attr;
  logic [5:0] out_x;
  logic       out_last;

  vid_text_fetch dut (
    .clk(clk), .rst_n(rst_n), .req_stb(req_stb), .req_y(req_y), .abort(abort),
    .busy(busy), .vp_x(vp_x), .vp_y(vp_y), .vp_sel(vp_sel), .vp_data(vp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_char(out_char),
    .out_attr(out_attr), .out_x(out_x), .out_last(out_last)
  );

  typedef struct {
    logic [7:0] ch;
    logic [3:0] at;
    logic [5:0] x;
    logic       last;
  } exp_t;

  exp_t expq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_char   = 0;
  int   ready_mode = 1;   // 0 = hold low, 1 = high, 2 = random 50%
  bit   pair_en  = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name, input string detail);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  // Screen RAM model: 3-cycle read latency, junk in the unused attribute bits.
  logic [7:0] d1, d2, d3;
  always @(posedge clk) begin
    d3 <= d2;
    d2 <= d1;
    if (vp_sel) d1 <= {4'($urandom), 4'(vp_x ^ 6'(vp_y))};
    else        d1 <= 8'(int'(vp_x) + 16 * int'(vp_y));
  end
  assign vp_data = d3;

  // Consumer ready driver.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output monitor: pops the scoreboard on every accepted cell.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        check(1'b0, "unexpected_cell", $sformatf("got x=%0d char=%0h, expected none", out_x, out_char));
      end else begin
        exp_t e;
        e = expq.pop_front();
        check({out_char, out_attr, out_x, out_last} == {e.ch, e.at, e.x, e.last}, "cell",
              $sformatf("got char=%0h attr=%0h x=%0d last=%0b, expected char=%0h attr=%0h x=%0d last=%0b",
                        out_char, out_attr, out_x, out_last, e.ch, e.at, e.x, e.last));
      end
    end
  end

  // Read-port monitor: counts char reads and checks each is followed by its attribute read.
  logic [11:0] vp_prev = '0;
  bit          vp_pend = 1'b0;
  always @(negedge clk) begin
    logic [11:0] cur;
    cur = {vp_x, vp_y, vp_sel};
    if (pair_en && vp_pend) begin
      check(cur == {vp_prev[11:1], 1'b1}, "read_pair",
            $sformatf("got x=%0d y=%0d sel=%0b, expected attr read x=%0d y=%0d",
                      vp_x, vp_y, vp_sel, vp_prev[11:6], vp_prev[5:1]));
    end
    vp_pend = (cur != vp_prev) && !vp_sel;
    if (vp_pend) n_char++;
    vp_prev = cur;
  end

  task automatic send_req(input logic [4:0] y);
    @(posedge clk);
    #1;
    req_stb = 1'b1;
    req_y   = y;
    for (int x = 0; x < 48; x++) begin
      exp_t e;
      e.ch   = 8'(x + 16 * int'(y));
      e.at   = 4'(x ^ int'(y));
      e.x    = 6'(x);
      e.last = (x == 47);
      expq.push_back(e);
    end
    @(posedge clk);
    #1;
    req_stb = 1'b0;
  endtask

  task automatic wait_idle(input int start, input bit timed);
    int cyc;
    int first_v;
    cyc = start;
    first_v = -1;
    while (busy && cyc < 4000) begin
      if (out_valid && first_v < 0) first_v = cyc;
      @(posedge clk);
      #1;
      cyc++;
    end
    check(!busy, "idle_timeout", $sformatf("busy=%0b after %0d cycles, expected 0", busy, cyc));
    if (timed) begin
      check(first_v == 6, "first_valid", $sformatf("got cycle %0d, expected 6", first_v));
      check(cyc == 101, "busy_drop", $sformatf("got cycle %0d, expected 101", cyc));
    end
    check(expq.size() == 0, "all_cells", $sformatf("%0d cells outstanding, expected 0", expq.size()));
  endtask

  task automatic run_row(input logic [4:0] y, input bit timed);
    send_req(y);
    wait_idle(1, timed);
  endtask

  task automatic check_reset_outputs(input string name);
    check({busy, vp_x, vp_y, vp_sel, out_valid, out_char, out_attr, out_x, out_last} == '0, name,
          $sformatf("got busy=%0b vp=%0d/%0d/%0b valid=%0b char=%0h attr=%0h x=%0d last=%0b, expected all 0",
                    busy, vp_x, vp_y, vp_sel, out_valid, out_char, out_attr, out_x, out_last));
  endtask

  initial begin
    logic [11:0] vp_snap;
    bit          saw_busy;
    int          n0;
    logic [4:0]  bad_y [3];

    rst_n = 1'b0; req_stb = 1'b0; req_y = '0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Free-flowing row with cycle-exact timing.
    ready_mode = 1;
    pair_en = 1'b1;
    run_row(5'd5, 1'b1);

    // Back-pressure: four cells buffered, char read stalled behind the credit limit.
    ready_mode = 0;
    send_req(5'd9);
    n0 = n_char;
    repeat (30) @(posedge clk);
    #1;
    check(n_char - n0 == 4, "bp_char_reads", $sformatf("got %0d, expected 4", n_char - n0));
    check(out_valid == 1'b1, "bp_valid", $sformatf("got %0b, expected 1", out_valid));
    check(vp_x == 6'd3 && vp_sel == 1'b1, "bp_stall_addr",
          $sformatf("got x=%0d sel=%0b, expected x=3 sel=1", vp_x, vp_sel));
    ready_mode = 1;
    wait_idle(31, 1'b0);

    // Random consumer, including the free-flowing row again.
    ready_mode = 2;
    run_row(5'd5, 1'b0);
    for (int i = 0; i < 3; i++) run_row(5'($urandom_range(0, 27)), 1'b0);
    ready_mode = 1;

    // Invalid rows and a request colliding with abort are all dropped.
    bad_y[0] = 5'd28; bad_y[1] = 5'd31; bad_y[2] = 5'd10;
    for (int i = 0; i < 3; i++) begin
      vp_snap = {vp_x, vp_y, vp_sel};
      @(posedge clk);
      #1;
      req_stb = 1'b1;
      req_y   = bad_y[i];
      abort   = (i == 2);
      @(posedge clk);
      #1;
      req_stb = 1'b0;
      abort   = 1'b0;
      saw_busy = 1'b0;
      for (int c = 0; c < 6; c++) begin
        if (busy) saw_busy = 1'b1;
        @(posedge clk);
        #1;
      end
      check(!saw_busy, "drop_busy", $sformatf("req_y=%0d busy seen=%0b, expected 0", bad_y[i], saw_busy));
      check({vp_x, vp_y, vp_sel} == vp_snap, "drop_vp",
            $sformatf("req_y=%0d got vp=%0h, expected %0h", bad_y[i], {vp_x, vp_y, vp_sel}, vp_snap));
    end

    // Abort mid-row, then a clean fetch of row 0.
    pair_en = 1'b0;
    send_req(5'd12);
    repeat (39) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    expq.delete();
    check(busy == 1'b0 && out_valid == 1'b0, "abort_flush",
          $sformatf("got busy=%0b valid=%0b, expected 0 0", busy, out_valid));
    saw_busy = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (out_valid || busy) saw_busy = 1'b1;
      @(posedge clk);
      #1;
    end
    check(!saw_busy, "abort_quiet", $sformatf("activity after abort=%0b, expected 0", saw_busy));
    pair_en = 1'b1;
    run_row(5'd0, 1'b1);

    // Asynchronous reset mid-row, then a normal fetch.
    pair_en = 1'b0;
    send_req(5'd7);
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    expq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    pair_en = 1'b1;
    run_row(5'd7, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
